// File: rtl/jpeg_frame_arbiter.sv
// jpeg_frame_arbiter
// Frame-granular two-way arbiter for the jpeg_core input stream. A requester
// owns the core for a whole frame, up to and including its last beat. The next
// grant waits until the core has reported idle for IDLE_CYCLES consecutive
// cycles, so the frame has fully drained. Completed frames are counted per
// requester, and a one-cycle done pulse names the requester that finished.
module jpeg_frame_arbiter #(
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             req0_valid_i,
    input  logic [31:0]      req0_data_i,
    input  logic [3:0]       req0_strb_i,
    input  logic             req0_last_i,
    output logic             req0_accept_o,
    input  logic             req1_valid_i,
    input  logic [31:0]      req1_data_i,
    input  logic [3:0]       req1_strb_i,
    input  logic             req1_last_i,
    output logic             req1_accept_o,
    output logic             core_valid_o,
    output logic [31:0]      core_data_o,
    output logic [3:0]       core_strb_o,
    output logic             core_last_o,
    input  logic             core_accept_i,
    input  logic             core_idle_i,
    output logic             owner_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             frame_done_id_o,
    output logic [CNT_W-1:0] frame_cnt0_o,
    output logic [CNT_W-1:0] frame_cnt1_o
);

    // Idle counter only has to reach IDLE_CYCLES-1 before the frame retires.
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]        state_r;
    logic              owner_r;
    logic              last_grant_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [CNT_W-1:0]  cnt0_r;
    logic [CNT_W-1:0]  cnt1_r;
    logic              done_r;
    logic              done_id_r;

    logic              grant_s;
    logic              grant_id_s;
    logic              core_valid_s;
    logic [31:0]       core_data_s;
    logic [3:0]        core_strb_s;
    logic              core_last_s;
    logic              acc0_s;
    logic              acc1_s;
    logic              xfer_s;

    // Grant decision in IDLE: single requester wins outright, a tie goes to
    // whichever requester did not own the previous frame.
    always_comb begin
        grant_id_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_id_s = ~last_grant_r;
        end else if (req1_valid_i) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        grant_s = (state_r == ST_IDLE) && enable_i && (req0_valid_i || req1_valid_i);
    end

    // Combinational beat mux: only the owner reaches the core, and only in STREAM.
    always_comb begin
        core_valid_s = 1'b0;
        core_data_s  = 32'h0000_0000;
        core_strb_s  = 4'h0;
        core_last_s  = 1'b0;
        acc0_s       = 1'b0;
        acc1_s       = 1'b0;
        case (state_r)
            ST_STREAM: begin
                if (owner_r) begin
                    core_valid_s = req1_valid_i;
                    core_data_s  = req1_data_i;
                    core_strb_s  = req1_strb_i;
                    core_last_s  = req1_last_i;
                    acc1_s       = core_accept_i;
                end else begin
                    core_valid_s = req0_valid_i;
                    core_data_s  = req0_data_i;
                    core_strb_s  = req0_strb_i;
                    core_last_s  = req0_last_i;
                    acc0_s       = core_accept_i;
                end
            end
            default: begin
                core_valid_s = 1'b0;
            end
        endcase
    end

    assign xfer_s = core_valid_s && core_accept_i;

    // Frame FSM: grant, stream until the last beat, then wait for a steady idle core.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            idle_cnt_r   <= '0;
            cnt0_r       <= '0;
            cnt1_r       <= '0;
            done_r       <= 1'b0;
            done_id_r    <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            done_id_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r <= ST_STREAM;
                        owner_r <= grant_id_s;
                    end
                end
                ST_STREAM: begin
                    if (xfer_s && core_last_s) begin
                        state_r    <= ST_DRAIN;
                        idle_cnt_r <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (core_idle_i) begin
                        if (idle_cnt_r == IDLE_LAST) begin
                            state_r      <= ST_IDLE;
                            done_r       <= 1'b1;
                            done_id_r    <= owner_r;
                            last_grant_r <= owner_r;
                            if (owner_r) begin
                                cnt1_r <= cnt1_r + CNT_ONE;
                            end else begin
                                cnt0_r <= cnt0_r + CNT_ONE;
                            end
                        end else begin
                            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
                        end
                    end else begin
                        idle_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_accept_o   = acc0_s;
    assign req1_accept_o   = acc1_s;
    assign core_valid_o    = core_valid_s;
    assign core_data_o     = core_data_s;
    assign core_strb_o     = core_strb_s;
    assign core_last_o     = core_last_s;
    // After reset owner_r is 0 and the state is IDLE, so owner_o reads 0.
    assign owner_o         = owner_r;
    assign busy_o          = (state_r != ST_IDLE);
    assign frame_done_o    = done_r;
    assign frame_done_id_o = done_id_r;
    assign frame_cnt0_o    = cnt0_r;
    assign frame_cnt1_o    = cnt1_r;

endmodule

// File: tb/tb_jpeg_frame_arbiter.sv
// Self-checking bench for jpeg_frame_arbiter: a cycle table for a single
// frame, then queue-driven requesters with a beat scoreboard and a
// frame-done queue for round-robin, drain gating, backpressure and wrap.
module tb_jpeg_frame_arbiter;

    localparam int IC = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          req0_valid_i, req1_valid_i;
    logic [31:0]   req0_data_i, req1_data_i;
    logic [3:0]    req0_strb_i, req1_strb_i;
    logic          req0_last_i, req1_last_i;
    logic          req0_accept_o, req1_accept_o;
    logic          core_valid_o;
    logic [31:0]   core_data_o;
    logic [3:0]    core_strb_o;
    logic          core_last_o;
    logic          core_accept_i;
    logic          core_idle_i;
    logic          owner_o, busy_o, frame_done_o, frame_done_id_o;
    logic [CW-1:0] frame_cnt0_o, frame_cnt1_o;

    jpeg_frame_arbiter #(.IDLE_CYCLES(IC), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_strb_i(req0_strb_i),
        .req0_last_i(req0_last_i), .req0_accept_o(req0_accept_o),
        .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_strb_i(req1_strb_i),
        .req1_last_i(req1_last_i), .req1_accept_o(req1_accept_o),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_strb_o(core_strb_o),
        .core_last_o(core_last_o), .core_accept_i(core_accept_i), .core_idle_i(core_idle_i),
        .owner_o(owner_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .frame_done_id_o(frame_done_id_o), .frame_cnt0_o(frame_cnt0_o), .frame_cnt1_o(frame_cnt1_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        id;
    } beat_t;

    typedef struct {
        logic        r0v;
        logic [31:0] r0d;
        logic        r0l;
        logic        r1v;
        logic        r1l;
        logic        acc;
        logic        idle;
        logic        e_cv;
        logic [31:0] e_cd;
        logic        e_cl;
        logic        e_a0;
        logic        e_a1;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_cnt0;
    } vec_t;

    beat_t   rq0[$];
    beat_t   rq1[$];
    beat_t   sb[$];
    logic    dq[$];
    logic [CW-1:0] m_cnt[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -1;
    int last_xfer_cyc = -1;
    int xfer_cnt = 0;
    int done_seen = 0;
    int lasts_seen = 0;
    logic first_beat = 1'b1;
    logic chk_turn = 1'b0;
    logic tog = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s got expired exp completed", name);
    endtask

    task automatic load_frame(input logic id, input int n, input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 32'(i);
            b.strb = (i == n - 1) ? 4'b0011 : 4'b1111;
            b.last = (i == n - 1);
            b.id   = id;
            if (id) rq1.push_back(b);
            else    rq0.push_back(b);
            sb.push_back(b);
        end
        dq.push_back(id);
    endtask

    // One clock cycle: present queue heads, check at negedge, pop on accept.
    task automatic step();
        logic x0, x1;
        beat_t b, e;
        if (tog) core_accept_i = ~core_accept_i;
        if (rq0.size() > 0) begin
            b = rq0[0];
            req0_valid_i = 1'b1; req0_data_i = b.data; req0_strb_i = b.strb; req0_last_i = b.last;
        end else begin
            req0_valid_i = 1'b0; req0_data_i = 32'h0; req0_strb_i = 4'h0; req0_last_i = 1'b0;
        end
        if (rq1.size() > 0) begin
            b = rq1[0];
            req1_valid_i = 1'b1; req1_data_i = b.data; req1_strb_i = b.strb; req1_last_i = b.last;
        end else begin
            req1_valid_i = 1'b0; req1_data_i = 32'h0; req1_strb_i = 4'h0; req1_last_i = 1'b0;
        end
        @(negedge clk);
        x0 = req0_valid_i && req0_accept_o;
        x1 = req1_valid_i && req1_accept_o;
        if (core_valid_o && core_accept_i) begin
            xfer_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", core_data_o, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("beat_data", core_data_o, e.data);
                chk("beat_strb", 32'(core_strb_o), 32'(e.strb));
                chk("beat_last", 32'(core_last_o), 32'(e.last));
                chk("beat_owner", 32'(owner_o), 32'(e.id));
                chk("owner_accept", 32'(e.id ? x1 : x0), 32'd1);
                chk("nonowner_accept", 32'(e.id ? req0_accept_o : req1_accept_o), 32'd0);
                if (chk_turn && first_beat && done_cyc >= 0)
                    chk("next_beat_gap", 32'(cyc - done_cyc), 32'd1);
                first_beat = e.last;
                if (e.last) begin
                    last_xfer_cyc = cyc;
                    lasts_seen++;
                end
            end
        end
        if (frame_done_o) begin
            done_seen++;
            done_cyc = cyc;
            chk("done_busy_low", 32'(busy_o), 32'd0);
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(frame_done_o), 32'd0);
            end else begin
                e.id = dq.pop_front();
                chk("done_id", 32'(frame_done_id_o), 32'(e.id));
                m_cnt[e.id] = m_cnt[e.id] + 4'd1;
                chk("done_cnt0", 32'(frame_cnt0_o), 32'(m_cnt[0]));
                chk("done_cnt1", 32'(frame_cnt1_o), 32'(m_cnt[1]));
                if (chk_turn) chk("done_gap", 32'(cyc - last_xfer_cyc), 32'(IC + 1));
            end
        end
        @(posedge clk);
        cyc++;
        if (x0) b = rq0.pop_front();
        if (x1) b = rq1.pop_front();
        #1;
    endtask

    task automatic run_until_empty(input int bound, input string name);
        int n = 0;
        while ((sb.size() > 0 || dq.size() > 0) && n < bound) begin
            step();
            n++;
        end
        if (sb.size() > 0 || dq.size() > 0) tmo(name);
    endtask

    task automatic clear_inputs();
        req0_valid_i = 1'b0; req0_data_i = 32'h0; req0_strb_i = 4'h0; req0_last_i = 1'b0;
        req1_valid_i = 1'b0; req1_data_i = 32'h0; req1_strb_i = 4'h0; req1_last_i = 1'b0;
    endtask

    // Main test sequence.
    initial begin
        vec_t vt[10];
        int d0, x0c, rise, n;
        vt[0] = '{1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vt[1] = '{1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11223344, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[2] = '{1'b1, 32'h55667788, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h55667788, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[3] = '{1'b1, 32'h99AABBCC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h99AABBCC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        for (int i = 4; i < 8; i++)
            vt[i] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1};
        vt[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};

        // Power-on reset
        rst_i = 1'b1; enable_i = 1'b0; core_accept_i = 1'b1; core_idle_i = 1'b1;
        clear_inputs();
        #2 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_valid", 32'(core_valid_o), 32'd0);
        chk("rst_acc0", 32'(req0_accept_o), 32'd0);
        chk("rst_acc1", 32'(req1_accept_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        chk("rst_done", 32'(frame_done_o), 32'd0);
        chk("rst_cnt0", 32'(frame_cnt0_o), 32'd0);
        chk("rst_cnt1", 32'(frame_cnt1_o), 32'd0);
        @(posedge clk); #1 rst_i = 1'b1;

        // Single frame, cycle by cycle from the table
        for (int i = 0; i < 10; i++) begin
            enable_i = 1'b1;
            core_accept_i = vt[i].acc; core_idle_i = vt[i].idle;
            req0_valid_i = vt[i].r0v; req0_data_i = vt[i].r0d; req0_last_i = vt[i].r0l;
            req0_strb_i = vt[i].r0v ? 4'hF : 4'h0;
            req1_valid_i = vt[i].r1v; req1_last_i = vt[i].r1l;
            req1_data_i = vt[i].r1v ? 32'hDEADBEEF : 32'h0;
            req1_strb_i = vt[i].r1v ? 4'hF : 4'h0;
            @(negedge clk);
            chk($sformatf("t%0d_cvalid", i), 32'(core_valid_o), 32'(vt[i].e_cv));
            chk($sformatf("t%0d_cdata", i), core_data_o, vt[i].e_cd);
            chk($sformatf("t%0d_cstrb", i), 32'(core_strb_o), vt[i].e_cv ? 32'hF : 32'h0);
            chk($sformatf("t%0d_clast", i), 32'(core_last_o), 32'(vt[i].e_cl));
            chk($sformatf("t%0d_acc0", i), 32'(req0_accept_o), 32'(vt[i].e_a0));
            chk($sformatf("t%0d_acc1", i), 32'(req1_accept_o), 32'(vt[i].e_a1));
            chk($sformatf("t%0d_busy", i), 32'(busy_o), 32'(vt[i].e_busy));
            chk($sformatf("t%0d_done", i), 32'(frame_done_o), 32'(vt[i].e_done));
            chk($sformatf("t%0d_cnt0", i), 32'(frame_cnt0_o), 32'(vt[i].e_cnt0));
            if (vt[i].e_done) chk($sformatf("t%0d_done_id", i), 32'(frame_done_id_o), 32'd0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a req1 frame
        clear_inputs();
        req1_valid_i = 1'b1; req1_data_i = 32'hCAFE0001; req1_strb_i = 4'hF;
        @(posedge clk); #1;
        #2;
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        chk("pre_rst_owner", 32'(owner_o), 32'd1);
        chk("pre_rst_cvalid", 32'(core_valid_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_owner", 32'(owner_o), 32'd0);
        chk("mid_rst_cvalid", 32'(core_valid_o), 32'd0);
        chk("mid_rst_cdata", core_data_o, 32'h0);
        chk("mid_rst_acc1", 32'(req1_accept_o), 32'd0);
        chk("mid_rst_cnt0", 32'(frame_cnt0_o), 32'd0);
        chk("mid_rst_done", 32'(frame_done_o), 32'd0);
        clear_inputs();
        @(posedge clk); #1 rst_i = 1'b1;
        m_cnt[0] = '0; m_cnt[1] = '0;

        // Round-robin: two 2-beat frames per requester, order 0,1,0,1
        enable_i = 1'b1; core_accept_i = 1'b1; core_idle_i = 1'b1;
        chk_turn = 1'b1; first_beat = 1'b1; done_cyc = -1;
        load_frame(1'b0, 2, 32'hA000_0000);
        load_frame(1'b1, 2, 32'hB000_0000);
        load_frame(1'b0, 2, 32'hA100_0000);
        load_frame(1'b1, 2, 32'hB100_0000);
        run_until_empty(200, "round_robin");
        chk("rr_cnt0", 32'(frame_cnt0_o), 32'd2);
        chk("rr_cnt1", 32'(frame_cnt1_o), 32'd2);

        // Drain gating: idle 0x10, 1x2, 0x1, then 1
        chk_turn = 1'b0;
        core_idle_i = 1'b0;
        load_frame(1'b0, 2, 32'hC000_0000);
        load_frame(1'b1, 1, 32'hD000_0000);
        d0 = lasts_seen; n = 0;
        while (lasts_seen == d0 && n < 50) begin step(); n++; end
        if (lasts_seen == d0) tmo("drain_last_beat");
        d0 = done_seen; x0c = xfer_cnt;
        repeat (10) step();
        core_idle_i = 1'b1; repeat (2) step();
        core_idle_i = 1'b0; step();
        chk("drain_no_early_done", 32'(done_seen - d0), 32'd0);
        core_idle_i = 1'b1; rise = cyc; n = 0;
        while (done_seen == d0 && n < 20) begin step(); n++; end
        if (done_seen == d0) tmo("drain_done");
        chk("drain_done_gap", 32'(done_cyc - rise), 32'(IC));
        chk("drain_no_grant", 32'(xfer_cnt - x0c), 32'd0);
        run_until_empty(50, "drain_tail");

        // Backpressure with enable dropped mid-frame
        tog = 1'b1;
        load_frame(1'b0, 5, 32'hE000_0000);
        load_frame(1'b1, 2, 32'hF000_0000);
        repeat (3) step();
        enable_i = 1'b0;
        d0 = done_seen; n = 0;
        while (done_seen == d0 && n < 100) begin step(); n++; end
        if (done_seen == d0) tmo("bp_frame");
        repeat (10) step();
        chk("bp_no_grant_busy", 32'(busy_o), 32'd0);
        chk("bp_r1_pending", 32'(rq1.size()), 32'd2);
        enable_i = 1'b1;
        run_until_empty(100, "bp_tail");
        chk("bp_all_consumed", 32'(rq0.size() + rq1.size()), 32'd0);
        tog = 1'b0; core_accept_i = 1'b1;

        // Counter wrap: 16 frames from req1 after a fresh reset
        rst_i = 1'b0; #1;
        @(posedge clk); #1 rst_i = 1'b1;
        m_cnt[0] = '0; m_cnt[1] = '0;
        chk_turn = 1'b1; first_beat = 1'b1; done_cyc = -1;
        for (int i = 0; i < 16; i++) load_frame(1'b1, 1, 32'h7000_0000 + 32'(i));
        run_until_empty(400, "wrap");
        chk("wrap_cnt1", 32'(frame_cnt1_o), 32'd0);
        chk("wrap_cnt0", 32'(frame_cnt0_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jpeg_frame_arbiter.md
# jpeg_frame_arbiter

Frame-granular arbiter that shares the single `jpeg_core` input stream between two independent JPEG byte-stream requesters. It sits in front of `jpeg_core.inport_*`. It grants one requester for a whole frame, forwarding beats up to and including the `last` beat. It then waits for the core's `idle_o` to show the frame has fully drained before granting again. It also reports which requester owns the pixels currently leaving the core, and keeps per-requester completed-frame counts.

## Interface
- `IDLE_CYCLES`, 16: consecutive cycles `core_idle_i` must be high after a frame's last beat before the frame is declared done. Must be at least 1; it must cover the core's pipeline start-up latency.
- `CNT_W`, 16: width of the per-requester frame counters.
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: permits new grants. It has no effect on a frame already granted.
- `req0_valid_i` / `req1_valid_i` in 1: requester beat valid.
- `req0_data_i` / `req1_data_i` in 32: JPEG bytes, same packing as the core `inport_data_i`.
- `req0_strb_i` / `req1_strb_i` in 4: byte strobes.
- `req0_last_i` / `req1_last_i` in 1: final beat of the frame.
- `req0_accept_o` / `req1_accept_o` out 1: beat accepted.
- `core_valid_o` out 1, `core_data_o` out 32, `core_strb_o` out 4, `core_last_o` out 1: to core `inport_*`.
- `core_accept_i` in 1: core `inport_accept_o`.
- `core_idle_i` in 1: core `idle_o`.
- `owner_o` out 1: requester owning the current or last frame. It is valid while `busy_o` is high.
- `busy_o` out 1: high in STREAM and DRAIN.
- `frame_done_o` out 1: one-cycle pulse when a frame completes.
- `frame_done_id_o` out 1: requester of the completing frame. Valid only with `frame_done_o`.
- `frame_cnt0_o` / `frame_cnt1_o` out `CNT_W`: completed frames per requester. These counters wrap.

## Operation
- States are IDLE, STREAM and DRAIN. Registers are `state`, `owner`, `last_grant`, `idle_cnt`, the frame counters and `frame_done`.
- **IDLE**
  - If `enable_i` is high and any `reqN_valid_i` is high, grant a requester and go to STREAM at the next edge.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one that is not `last_grant` (round-robin).
  - No beat is accepted in IDLE.
- **STREAM**
  - The mux is combinational. `core_valid_o`, `core_data_o`, `core_strb_o` and `core_last_o` come from the owner's inputs.
  - The owner's accept equals `core_accept_i`. The non-owner's accept is 0.
  - A beat transfers when the owner's valid and `core_accept_i` are both high.
  - When a transferring beat has `last` high, go to DRAIN and clear `idle_cnt`.
- **DRAIN**
  - `core_valid_o` is 0 and both accepts are 0.
  - Each cycle: if `core_idle_i` is high, `idle_cnt` increments; otherwise it clears to 0.
  - When `core_idle_i` is high and `idle_cnt == IDLE_CYCLES-1`, go to IDLE at the next edge. At that same edge:
    - register `frame_done_o` high and `frame_done_id_o` to `owner`;
    - increment the owner's counter (`2^CNT_W-1` wraps to 0);
    - set `last_grant` to `owner`.
- In IDLE and DRAIN, `core_data_o`, `core_strb_o` and `core_last_o` are 0.
- A frame is never aborted. Deasserting `enable_i` mid-frame only blocks the next grant.
- A `last` beat presented by the non-owner is ignored, and that requester stalls.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE, `owner` is 0, and `last_grant` is 1, so requester 0 wins the first tie. Reset asserts asynchronously and deasserts synchronously to the design's reset scheme. Reset mid-STREAM drops the frame with no done pulse.
- **Grant latency:** valid seen in IDLE at edge T gives STREAM from T+1. The first beat can transfer in the T+1 cycle.
- **Turnaround:** last beat transfers at T, and `core_idle_i` is high continuously from T+1. Then:
  - `frame_done_o` is high in cycle T+IDLE_CYCLES+1, with the state already IDLE;
  - the earliest next beat transfers at T+IDLE_CYCLES+2.
- **Handshake:** the arbiter adds no buffering and never drops or duplicates a beat. Stability of data under backpressure is the requester's responsibility and is passed through unchanged.
- `owner_o` changes only on the IDLE→STREAM edge and holds through DRAIN and the done cycle.

## Test plan
- **Reset:** assert `rst_i`=0 mid-STREAM.
  - All outputs go to 0 immediately (asynchronously).
  - After release, the next tie grants req0.
- **Single frame:** req0 sends 3 beats (0x11223344, 0x55667788, 0x99AABBCC with last), `core_accept_i`=1, idle held 1, `IDLE_CYCLES`=4.
  - The beats appear on `core_*`; `req1_accept_o` stays 0.
  - `frame_done_o` pulses 5 cycles after the last beat, with `frame_done_id_o`=0 and `frame_cnt0_o`=1.
- **Round-robin:** both requesters stream 2-beat frames continuously.
  - Grant order is 0,1,0,1.
  - After 4 frames, `frame_cnt0_o`=2 and `frame_cnt1_o`=2.
- **Drain gating:** after the last beat, idle is 0 for 10 cycles, then 1 for 2 cycles, 0 for 1 cycle, then 1.
  - `frame_done_o` pulses exactly `IDLE_CYCLES` cycles after the final rise.
  - No grant happens before the pulse.
- **Backpressure and enable:** `core_accept_i` toggles every cycle, and `enable_i` drops mid-frame.
  - Every beat is transferred exactly once and the frame completes.
  - No new grant occurs until `enable_i` is 1 again.
- **Counter wrap:** with `CNT_W`=4, req1 completes 16 frames; `frame_cnt1_o` reads 0.
